rvc_ci_unit: RTL

Multi-cycle execution unit for RV32C/RV64C CI-format instructions: c.lwsp, c.ldsp, c.li, c.lui, c.addi, c.addi16sp, c.slli and c.nop. It is the sequential successor of the single-cycle CI datapath in `rtl/core/alu/standard_extension/rvc/`. It adds an XLEN parameter, a wait-stated RAM handshake, two-beat doubleword loads, and illegal/misaligned reporting. It sits between the compressed decoder (valid/ready issue) and the register-file writeback port.

---
 rtl/rvc_pkg.sv | 49 ++++
 rtl/rvc_ci_decode.sv | 76 +++++++
 rtl/rvc_ci_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rvc_pkg.sv
// Shared definitions for the compressed-instruction execution units:
// quadrant/funct3 codes, FSM encoding and immediate extraction helpers.
package rvc_pkg;

  localparam logic [1:0] C_OP_Q1 = 2'b01;
  localparam logic [1:0] C_OP_Q2 = 2'b10;

  localparam logic [2:0] C_F3_ADDI = 3'b000;
  localparam logic [2:0] C_F3_LI   = 3'b010;
  localparam logic [2:0] C_F3_LUI  = 3'b011;
  localparam logic [2:0] C_F3_SLLI = 3'b000;
  localparam logic [2:0] C_F3_LWSP = 3'b010;
  localparam logic [2:0] C_F3_LDSP = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_RESP
  } ci_state_e;

  typedef enum logic [2:0] {
    K_LI,
    K_LUI,
    K_ADDI16SP,
    K_ADDI,
    K_SLLI,
    K_LWSP,
    K_LDSP
  } ci_kind_e;

  // Helpers return 64-bit values; narrower datapaths truncate the result.
  function automatic logic [63:0] ci_imm6(input logic [15:0] ir);
    return {{58{ir[12]}}, ir[12], ir[6:2]};
  endfunction

  function automatic logic [63:0] ci_nzimm16sp(input logic [15:0] ir);
    return {{54{ir[12]}}, ir[12], ir[4:3], ir[5], ir[2], ir[6], 4'b0000};
  endfunction

  function automatic logic [63:0] ci_lwsp_off(input logic [15:0] ir);
    return {56'd0, ir[3:2], ir[12], ir[6:4], 2'b00};
  endfunction

  function automatic logic [63:0] ci_ldsp_off(input logic [15:0] ir);
    return {55'd0, ir[4:2], ir[12], ir[6:5], 3'b000};
  endfunction

endpackage

// File: rtl/rvc_ci_decode.sv
// Combinational CI-format decode: instruction kind, extended immediate and
// the illegal flag for the configured XLEN.
module rvc_ci_decode
  import rvc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [15:0]     ir,
  output logic [2:0]      kind,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [1:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [63:0] imm64;

  assign op = ir[1:0];
  assign f3 = ir[15:13];
  assign rd = ir[11:7];

  always_comb begin
    kind    = K_LI;
    imm64   = '0;
    illegal = 1'b1;
    if (op == C_OP_Q1) begin
      case (f3)
        C_F3_LI: begin
          kind    = K_LI;
          imm64   = ci_imm6(ir);
          illegal = 1'b0;
        end
        C_F3_LUI: begin
          if (rd == 5'd2) begin
            kind    = K_ADDI16SP;
            imm64   = ci_nzimm16sp(ir);
            illegal = (imm64 == 64'd0);
          end else begin
            kind    = K_LUI;
            imm64   = ci_imm6(ir) << 12;
            illegal = ({ir[12], ir[6:2]} == 6'd0);
          end
        end
        C_F3_ADDI: begin
          kind    = K_ADDI;
          imm64   = ci_imm6(ir);
          illegal = 1'b0;
        end
        default: ;
      endcase
    end else if (op == C_OP_Q2) begin
      case (f3)
        C_F3_SLLI: begin
          kind    = K_SLLI;
          imm64   = {58'd0, ir[12], ir[6:2]};
          illegal = (XLEN == 32) && ir[12];
        end
        C_F3_LWSP: begin
          kind    = K_LWSP;
          imm64   = ci_lwsp_off(ir);
          illegal = (rd == 5'd0);
        end
        C_F3_LDSP: begin
          kind    = K_LDSP;
          imm64   = ci_ldsp_off(ir);
          illegal = (XLEN != 64) || (rd == 5'd0);
        end
        default: ;
      endcase
    end
  end

  assign imm = XLEN'(imm64);

endmodule

// File: rtl/rvc_ci_unit.sv
// Multi-cycle CI-format execution unit: valid/ready issue, wait-stated RAM
// loads (one or two beats) and a registered one-cycle writeback pulse.
module rvc_ci_unit
  import rvc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RAM_AW = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic [15:0]       iIR,
  input  logic [XLEN-1:0]   iRS1,
  input  logic [XLEN-1:0]   iSP,
  output logic              oVALID,
  output logic              oWE,
  output logic [4:0]        oRD,
  output logic [XLEN-1:0]   oWDATA,
  output logic              oILLEGAL,
  output logic              oMISALIGNED,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic [RAM_AW-1:0] oRAM_ADDR,
  input  logic [31:0]       iRAM_DATA,
  input  logic              iRAM_VALID
);

  localparam int BAW = RAM_AW + 2;

  ci_state_e         state_q, state_d;
  logic              ram_ce_q, ram_ce_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ld_dw_q, ld_dw_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [31:0]       beat0_q, beat0_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              ill_q, ill_d;
  logic              mis_q, mis_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic [2:0]        dec_kind_raw;
  ci_kind_e          dec_kind;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;

  logic              accept;
  logic              is_load;
  logic              misaligned;
  logic [4:0]        rd_in;
  logic [BAW-1:0]    byte_addr;
  logic [XLEN-1:0]   alu_res;

  rvc_ci_decode #(.XLEN(XLEN)) u_decode (
    .ir      (iIR),
    .kind    (dec_kind_raw),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign dec_kind   = ci_kind_e'(dec_kind_raw);
  assign oREADY     = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign accept     = iVALID && oREADY;
  assign rd_in      = iIR[11:7];
  assign is_load    = (dec_kind == K_LWSP) || (dec_kind == K_LDSP);
  assign byte_addr  = iSP[BAW-1:0] + dec_imm[BAW-1:0];
  assign misaligned = is_load && !dec_illegal &&
                      ((dec_kind == K_LDSP) ? (byte_addr[2:0] != 3'd0)
                                            : (byte_addr[1:0] != 2'd0));

  always_comb begin
    alu_res = '0;
    case (dec_kind)
      K_LI, K_LUI: alu_res = dec_imm;
      K_ADDI:      alu_res = iRS1 + dec_imm;
      K_ADDI16SP:  alu_res = iSP + dec_imm;
      K_SLLI:      alu_res = iRS1 << dec_imm[5:0];
      default:     alu_res = '0;
    endcase
  end

  // Writeback fields hold their value except in the cycle that raises valid_d.
  always_comb begin
    state_d    = state_q;
    ram_ce_d   = ram_ce_q;
    ram_addr_d = ram_addr_q;
    ld_dw_d    = ld_dw_q;
    pend_rd_d  = pend_rd_q;
    beat0_d    = beat0_q;
    valid_d    = 1'b0;
    we_d       = we_q;
    ill_d      = ill_q;
    mis_d      = mis_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d  = ST_IDLE;
        ram_ce_d = 1'b0;
        if (accept) begin
          pend_rd_d = rd_in;
          ld_dw_d   = (dec_kind == K_LDSP);
          if (is_load && !dec_illegal && !misaligned) begin
            state_d    = ST_LOAD0;
            ram_ce_d   = 1'b1;
            ram_addr_d = byte_addr[BAW-1:2];
          end else begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            rd_d    = rd_in;
            ill_d   = dec_illegal;
            mis_d   = misaligned;
            we_d    = !dec_illegal && !misaligned && (rd_in != 5'd0);
            wdata_d = (dec_illegal || misaligned) ? '0 : alu_res;
          end
        end
      end
      ST_LOAD0: begin
        if (iRAM_VALID) begin
          if (ld_dw_q) begin
            state_d    = ST_LOAD1;
            beat0_d    = iRAM_DATA;
            ram_addr_d = ram_addr_q + RAM_AW'(1);
          end else begin
            state_d  = ST_RESP;
            ram_ce_d = 1'b0;
            valid_d  = 1'b1;
            rd_d     = pend_rd_q;
            ill_d    = 1'b0;
            mis_d    = 1'b0;
            we_d     = 1'b1;
            wdata_d  = XLEN'({{32{iRAM_DATA[31]}}, iRAM_DATA});
          end
        end
      end
      ST_LOAD1: begin
        if (iRAM_VALID) begin
          state_d  = ST_RESP;
          ram_ce_d = 1'b0;
          valid_d  = 1'b1;
          rd_d     = pend_rd_q;
          ill_d    = 1'b0;
          mis_d    = 1'b0;
          we_d     = 1'b1;
          wdata_d  = XLEN'({iRAM_DATA, beat0_q});
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      ram_ce_q   <= 1'b0;
      ram_addr_q <= '0;
      ld_dw_q    <= 1'b0;
      pend_rd_q  <= '0;
      beat0_q    <= '0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      mis_q      <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ram_ce_q   <= ram_ce_d;
      ram_addr_q <= ram_addr_d;
      ld_dw_q    <= ld_dw_d;
      pend_rd_q  <= pend_rd_d;
      beat0_q    <= beat0_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      ill_q      <= ill_d;
      mis_q      <= mis_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign oVALID      = valid_q;
  assign oWE         = we_q;
  assign oRD         = rd_q;
  assign oWDATA      = wdata_q;
  assign oILLEGAL    = ill_q;
  assign oMISALIGNED = mis_q;
  assign oRAM_CE     = ram_ce_q;
  assign oRAM_RD     = ram_ce_q;
  assign oRAM_ADDR   = ram_addr_q;

endmodule
